// File: rtl/sfp_norm_seq.sv
// sfp_norm_seq: handshaked row normaliser, out[c] = (|x[c]| << OUT_SHIFT) / sum_abs, with optional partner-sum exchange
module sfp_norm_seq #(
  parameter int COL = 8,
  parameter int BW_PSUM = 20,
  parameter int OUT_SHIFT = 8,
  parameter int SW = BW_PSUM + $clog2(COL),
  parameter int BW_OUT = OUT_SHIFT + 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode_signed,
  input  logic                      mode_dual,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL*BW_PSUM-1:0]    in_row,
  output logic [SW-1:0]             sum_out,
  output logic                      sum_out_valid,
  input  logic [SW:0]               sum_in,
  input  logic                      sum_in_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COL*BW_OUT-1:0]     out_row,
  output logic                      busy
);
  localparam int QW = OUT_SHIFT + 1;
  localparam int CW = $clog2(QW + 1);
  localparam int RW = SW + 2;
  typedef enum logic [2:0] {IDLE, SUM, XCHG, DIV, DONE} state_t;
  state_t state, nxt;
  logic [BW_PSUM-1:0] abs_r [COL];
  logic [BW_PSUM-1:0] lane_in [COL];
  logic [BW_PSUM-1:0] abs_in [COL];
  logic [RW-1:0] rem [COL];
  logic [RW-1:0] rem_nx [COL];
  logic [QW-2:0] quo [COL];
  logic [QW-1:0] q_fin [COL];
  logic [COL-1:0] sgn, ge;
  logic [SW:0] div, partner, dsum;
  logic [SW-1:0] sum_abs, sum_c;
  logic [CW-1:0] cnt;
  logic [COL*BW_OUT-1:0] row_fin;
  logic smode, dmode, accept;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign sum_out_valid = state == XCHG;
  assign busy = state != IDLE;
  assign sum_out = sum_abs;
  assign dsum = {1'b0, sum_abs} + partner;
  // The remainder is compared against the fixed divisor and doubled each step; valid because |x| <= divisor.
  always_comb begin
    sum_c = '0;
    row_fin = '0;
    ge = '0;
    for (int c = 0; c < COL; c++) begin
      lane_in[c] = in_row[c*BW_PSUM +: BW_PSUM];
      abs_in[c] = lane_in[c][BW_PSUM-1] ? -lane_in[c] : lane_in[c];
      sum_c = sum_c + {{(SW-BW_PSUM){1'b0}}, abs_r[c]};
      ge[c] = rem[c] >= {1'b0, div};
      rem_nx[c] = (ge[c] ? rem[c] - {1'b0, div} : rem[c]) << 1;
      q_fin[c] = {quo[c], ge[c]};
      row_fin[c*BW_OUT +: BW_OUT] = smode && sgn[c] ? -{1'b0, q_fin[c]} : {1'b0, q_fin[c]};
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? SUM : IDLE;
      SUM:     nxt = dmode ? XCHG : DIV;
      XCHG:    nxt = sum_in_valid ? DIV : XCHG;
      DIV:     nxt = cnt == '0 ? DONE : DIV;
      DONE:    nxt = out_ready ? (in_valid ? SUM : IDLE) : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sum_abs <= '0;
      div <= '0;
      partner <= '0;
      cnt <= '0;
      smode <= 1'b0;
      dmode <= 1'b0;
      sgn <= '0;
      out_row <= '0;
      for (int c = 0; c < COL; c++) begin
        abs_r[c] <= '0;
        rem[c] <= '0;
        quo[c] <= '0;
      end
    end else begin
      state <= nxt;
      if (accept) begin
        for (int c = 0; c < COL; c++) begin
          abs_r[c] <= abs_in[c];
          sgn[c] <= lane_in[c][BW_PSUM-1];
        end
        smode <= mode_signed;
        dmode <= mode_dual;
        partner <= '0;
        cnt <= CW'(QW);
      end
      if (state == SUM) sum_abs <= sum_c;
      if (state == XCHG && sum_in_valid) partner <= sum_in;
      // First DIV cycle loads the divisor (zero forced to one) and seeds each remainder with |x|.
      if (state == DIV) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(QW)) begin
          div <= dsum == '0 ? (SW+1)'(1) : dsum;
          for (int c = 0; c < COL; c++) rem[c] <= {{(RW-BW_PSUM){1'b0}}, abs_r[c]};
        end else begin
          for (int c = 0; c < COL; c++) begin
            rem[c] <= rem_nx[c];
            quo[c] <= q_fin[c][QW-2:0];
          end
          if (cnt == '0) out_row <= row_fin;
        end
      end
    end
  end
endmodule

// File: tb/tb_sfp_norm_seq.sv
// tb_sfp_norm_seq: directed and random rows checked against a plain-arithmetic normaliser model
module tb_sfp_norm_seq;
  localparam int COL = 8, BW_PSUM = 20, OUT_SHIFT = 8, SW = 23, BW_OUT = 10, OW = COL*BW_OUT;
  typedef logic [COL*BW_PSUM-1:0] row_t;
  typedef logic [OW-1:0] orow_t;
  typedef struct {
    orow_t row;
    logic [SW-1:0] lsum;
    logic [SW:0] pin;
    int pdly;
  } exp_t;
  logic clk = 0, reset = 1, mode_signed = 0, mode_dual = 0, in_valid = 0, out_ready = 1, sum_in_valid = 0;
  logic in_ready, sum_out_valid, out_valid, busy;
  row_t in_row = '0;
  logic [SW-1:0] sum_out;
  logic [SW:0] sum_in = '0;
  orow_t out_row;
  int tests = 0, fails = 0;
  bit rand_rdy = 0, force_rdy = 1;
  exp_t sb[$];
  orow_t held;
  bit hv = 0;
  int wc = 0;

  always #5 clk = ~clk;

  sfp_norm_seq dut (
    .clk(clk), .reset(reset), .mode_signed(mode_signed), .mode_dual(mode_dual),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid), .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .busy(busy)
  );

  function automatic exp_t model(row_t r, bit sg, bit du, logic [SW:0] pin, int pd);
    exp_t e;
    longint x, s, d, q;
    longint a [COL];
    bit neg [COL];
    s = 0;
    for (int c = 0; c < COL; c++) begin
      x = longint'($signed(r[c*BW_PSUM +: BW_PSUM]));
      neg[c] = x < 0;
      a[c] = neg[c] ? -x : x;
      s += a[c];
    end
    d = du ? s + longint'(pin) : s;
    if (d == 0) d = 1;
    e.lsum = SW'(s);
    e.pin = pin;
    e.pdly = pd;
    e.row = '0;
    for (int c = 0; c < COL; c++) begin
      q = (a[c] << OUT_SHIFT) / d;
      e.row[c*BW_OUT +: BW_OUT] = BW_OUT'((sg && neg[c]) ? -q : q);
    end
    return e;
  endfunction

  function automatic row_t mk(int v0, int v1);
    row_t r = '0;
    r[0 +: BW_PSUM] = BW_PSUM'(v0);
    r[BW_PSUM +: BW_PSUM] = BW_PSUM'(v1);
    return r;
  endfunction

  function automatic orow_t ok2(int q0, int q1);
    orow_t o = '0;
    o[0 +: BW_OUT] = BW_OUT'(q0);
    o[BW_OUT +: BW_OUT] = BW_OUT'(q1);
    return o;
  endfunction

  task automatic chk(input string nm, input orow_t act, input orow_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Every cycle with a result on the port: compare against the model, and require stability while stalled.
  always @(negedge clk) begin
    if (reset) hv = 0;
    else begin
      if (out_valid) begin
        if (hv) chk("hold", out_row, held);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: out_valid=1 with no row pending, want 0");
        end else begin
          chk("out_row", out_row, sb[0].row);
          if (out_ready) begin
            void'(sb.pop_front());
            hv = 0;
          end else begin
            held = out_row;
            hv = 1;
          end
        end
      end
      if (sum_out_valid && sb.size() > 0) chk("sum_out", orow_t'(sum_out), orow_t'(sb[0].lsum));
    end
  end

  // Consumer ready and partner core: partner answers after pdly idle XCHG cycles, noise otherwise.
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : force_rdy;
    if (sum_out_valid && sb.size() > 0) begin
      sum_in_valid = wc >= sb[0].pdly;
      sum_in = sum_in_valid ? sb[0].pin : (SW+1)'($urandom);
      wc = sum_in_valid ? 0 : wc + 1;
    end else begin
      wc = 0;
      sum_in_valid = 1'($urandom);
      sum_in = (SW+1)'($urandom);
    end
  end

  task automatic send(input row_t r, input bit sg, input bit du, input logic [SW:0] pin, input int pd,
                      output int waited);
    exp_t e = model(r, sg, du, pin, pd);
    waited = 0;
    in_row = r;
    mode_signed = sg;
    mode_dual = du;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, want 1", waited);
    end else sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
    mode_signed = 1'($urandom);
    mode_dual = 1'($urandom);
    in_row = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input string nm, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, want 1", nm, cyc);
    end
  endtask

  task automatic lat_chk(input string nm, input orow_t want);
    repeat (10) @(posedge clk);
    #1;
    chk({nm, "_early"}, orow_t'(out_valid), 0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, orow_t'(out_valid), 1);
    chk({nm, "_row"}, out_row, want);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, k;
    row_t r;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_in_ready", orow_t'(in_ready), 1);
    chk("rst_out_valid", orow_t'(out_valid), 0);
    chk("rst_sum_out_valid", orow_t'(sum_out_valid), 0);
    chk("rst_busy", orow_t'(busy), 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_sum_out", orow_t'(sum_out), 0);
    send(mk(256, -256), 1, 0, 0, 0, w);
    lat_chk("t1", ok2(128, -128));
    send(mk(-1000, 0), 1, 0, 0, 0, w);
    lat_chk("t2s", ok2(-256, 0));
    send(mk(-1000, 0), 0, 0, 0, 0, w);
    lat_chk("t2u", ok2(256, 0));
    send('0, 1, 0, 0, 0, w);
    lat_chk("t3", 0);
    send(mk(256, 256), 1, 1, 512, 4, w);
    @(posedge clk);
    #1;
    chk("t4_xchg", orow_t'(sum_out_valid), 1);
    chk("t4_sum_out", orow_t'(sum_out), 512);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_hold_xchg", orow_t'(sum_out_valid), 1);
    chk("t4_busy", orow_t'(busy), 1);
    wait_out("t4", w);
    chk("t4_lat", orow_t'(w), 11);
    chk("t4_row", out_row, ok2(64, 64));
    @(posedge clk);
    #1;
    force_rdy = 0;
    @(posedge clk);
    #2;
    send(mk(300, -100), 1, 0, 0, 0, w);
    wait_out("t5", w);
    chk("t5_row", out_row, ok2(192, -64));
    in_row = mk(-7, 21);
    mode_signed = 0;
    mode_dual = 0;
    in_valid = 1;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("t5_stable", out_row, ok2(192, -64));
      chk("t5_in_ready", orow_t'(in_ready), 0);
      chk("t5_out_valid", orow_t'(out_valid), 1);
    end
    force_rdy = 1;
    @(posedge clk);
    #2;
    send(mk(-7, 21), 0, 0, 0, 0, w);
    chk("t5_same_cycle", orow_t'(w), 0);
    chk("t5_busy", orow_t'(busy), 1);
    chk("t5_next_valid", orow_t'(out_valid), 0);
    wait_out("t5b", w);
    chk("t5b_row", out_row, ok2(64, 192));
    @(posedge clk);
    #1;
    send(mk(1000, 3000), 0, 0, 0, 0, w);
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 0;
    chk("t6_busy", orow_t'(busy), 0);
    chk("t6_out_valid", orow_t'(out_valid), 0);
    chk("t6_in_ready", orow_t'(in_ready), 1);
    send(mk(500, 250), 0, 0, 0, 0, w);
    lat_chk("t6", ok2(170, 85));
    rand_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      r = '0;
      for (int c = 0; c < COL; c++) begin
        k = $urandom_range(0, 7);
        r[c*BW_PSUM +: BW_PSUM] = k == 0 ? 20'h80000 : k == 1 ? 20'h0 : k == 2 ? 20'h7ffff : BW_PSUM'($urandom);
      end
      send(r, 1'($urandom), 1'($urandom), (SW+1)'($urandom_range(0, 1 << 22)), $urandom_range(0, 3), w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_rdy = 0;
    for (int i = 0; i < 300 && sb.size() > 0; i++) @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d rows outstanding, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
